// File: rtl/ara_pkg.sv
// Slice of Ara's shared package: instruction IDs, functional-unit enum, the PE request
// record and the helper that maps a functional unit onto its target PE mask.
package ara_pkg;

    localparam int unsigned NrVInsn = 8;
    localparam int unsigned NrLanes = 1;
    localparam int unsigned NrPEs   = NrLanes + 4;

    // PE index layout: lanes first, then the four units
    localparam int unsigned OffsetStore = NrLanes;
    localparam int unsigned OffsetLoad  = NrLanes + 1;
    localparam int unsigned OffsetMask  = NrLanes + 2;
    localparam int unsigned OffsetSlide = NrLanes + 3;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    typedef enum logic [2:0] {
        VFU_None,
        VFU_Alu,
        VFU_MFpu,
        VFU_SlideUnit,
        VFU_MaskUnit,
        VFU_LoadUnit,
        VFU_StoreUnit
    } vfu_e;

    typedef struct packed {
        vid_t               id;
        logic [7:0]         op;
        vfu_e               vfu;
        logic [4:0]         vs1;
        logic [4:0]         vs2;
        logic [4:0]         vd;
        logic               vm;
        logic [15:0]        vl;
        logic [NrVInsn-1:0] hazard_vs1;
        logic [NrVInsn-1:0] hazard_vs2;
        logic [NrVInsn-1:0] hazard_vd;
        logic [NrVInsn-1:0] hazard_vm;
        logic [NrVInsn-1:0] vinsn_running;
    } pe_req_t;

    // Every real unit involves the lanes; a masked instruction (vm = 0) also needs the mask unit.
    function automatic logic [NrPEs-1:0] pe_mask(vfu_e vfu, logic vm);
        logic [NrPEs-1:0] m;
        m = '0;
        if (vfu != VFU_None) begin
            m[NrLanes-1:0] = '1;
            if (!vm) m[OffsetMask] = 1'b1;
        end
        case (vfu)
            VFU_LoadUnit:  m[OffsetLoad]  = 1'b1;
            VFU_StoreUnit: m[OffsetStore] = 1'b1;
            VFU_SlideUnit: m[OffsetSlide] = 1'b1;
            VFU_MaskUnit:  m[OffsetMask]  = 1'b1;
            default:       ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ara_pe_req_broadcast_if.sv
// Bundle of the sequencer-side and PE-side signals around the request broadcaster.
// master = sequencer and PEs, slave = the broadcaster.
interface ara_pe_req_broadcast_if
    import ara_pkg::pe_req_t;
#(
    parameter int unsigned NrPEs   = 5,
    parameter int unsigned NrVInsn = ara_pkg::NrVInsn
) ();

    pe_req_t            req;
    logic [NrPEs-1:0]   req_pes;
    logic               req_valid;
    logic               req_ready;
    logic [NrVInsn-1:0] vinsn_running;
    pe_req_t            pe_req;
    logic [NrPEs-1:0]   pe_req_valid;
    logic [NrPEs-1:0]   pe_req_ready;
    logic               busy;
    logic [15:0]        stall_cycles;

    modport master (
        output req, req_pes, req_valid, vinsn_running, pe_req_ready,
        input  req_ready, pe_req, pe_req_valid, busy, stall_cycles
    );

    modport slave (
        input  req, req_pes, req_valid, vinsn_running, pe_req_ready,
        output req_ready, pe_req, pe_req_valid, busy, stall_cycles
    );

endinterface

// File: rtl/ara_pe_req_broadcast.sv
// Queues sequencer requests and broadcasts the head to a per-request PE subset; each PE
// accepts independently and queued hazard bits are pruned every cycle.
module ara_pe_req_broadcast
    import ara_pkg::pe_req_t;
#(
    parameter int unsigned NrPEs   = 5,
    parameter int unsigned NrVInsn = ara_pkg::NrVInsn,
    parameter int unsigned Depth   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  pe_req_t            req_i,
    input  logic [NrPEs-1:0]   req_pes_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [NrVInsn-1:0] vinsn_running_i,
    output pe_req_t            pe_req_o,
    output logic [NrPEs-1:0]   pe_req_valid_o,
    input  logic [NrPEs-1:0]   pe_req_ready_i,
    output logic               busy_o,
    output logic [15:0]        stall_cycles_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    function automatic pe_req_t prune(pe_req_t r, logic [NrVInsn-1:0] running);
        pe_req_t p;
        p               = r;
        p.hazard_vs1    = r.hazard_vs1 & running;
        p.hazard_vs2    = r.hazard_vs2 & running;
        p.hazard_vd     = r.hazard_vd  & running;
        p.hazard_vm     = r.hazard_vm  & running;
        p.vinsn_running = running;
        return p;
    endfunction

    pe_req_t          r_data [Depth];
    logic [NrPEs-1:0] r_pend [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [PtrW:0]    r_count;
    logic [15:0]      r_stall;

    pe_req_t          w_data_next [Depth];
    logic [NrPEs-1:0] w_pend_next [Depth];
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [NrPEs-1:0] w_valid;
    logic [NrPEs-1:0] w_acc;
    logic [NrPEs-1:0] w_left;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (PtrW+1)'(Depth));
    assign req_ready_o = !w_full && !rst_i;
    // A request with no targets is swallowed by the handshake and never stored
    assign w_push      = req_valid_i && req_ready_o && (|req_pes_i);

    assign w_valid = w_empty ? '0 : r_pend[r_rptr];
    assign w_acc   = w_valid & pe_req_ready_i;
    assign w_left  = w_valid & ~pe_req_ready_i;
    assign w_pop   = !w_empty && (w_left == '0);

    assign pe_req_o       = w_empty ? '0 : r_data[r_rptr];
    assign pe_req_valid_o = w_valid;
    assign busy_o         = !w_empty;
    assign stall_cycles_o = r_stall;

    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        localparam logic [PtrW-1:0] Idx = PtrW'(gi);
        logic w_wr;
        logic w_is_head;

        assign w_wr        = w_push && (r_wptr == Idx);
        assign w_is_head   = !w_empty && (r_rptr == Idx);
        // Refreshing free slots is harmless: they are overwritten on their next write
        assign w_data_next[gi] = prune(w_wr ? req_i : r_data[gi], vinsn_running_i);
        assign w_pend_next[gi] = w_wr      ? req_pes_i :
                                 w_is_head ? (r_pend[gi] & ~w_acc) : r_pend[gi];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_data[i] <= '0;
                r_pend[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_stall <= '0;
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_data[i] <= w_data_next[i];
                r_pend[i] <= w_pend_next[i];
            end
            if (w_push) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
            r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
            if (w_pop)
                r_stall <= '0;
            else if (!w_empty && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
        end
    end

endmodule

// File: tb/tb_ara_pe_req_broadcast.sv
// Bench for the PE request broadcaster: directed scenario tasks plus a queue scoreboard
// that tracks every stored request and compares it against the broadcast head each cycle.
module tb_ara_pe_req_broadcast;
    import ara_pkg::*;

    localparam int Pes = 5;
    localparam int Dep = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ara_pe_req_broadcast_if #(.NrPEs(Pes)) bus ();

    ara_pe_req_broadcast #(.NrPEs(Pes), .NrVInsn(NrVInsn), .Depth(Dep)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (bus.req),
        .req_pes_i       (bus.req_pes),
        .req_valid_i     (bus.req_valid),
        .req_ready_o     (bus.req_ready),
        .vinsn_running_i (bus.vinsn_running),
        .pe_req_o        (bus.pe_req),
        .pe_req_valid_o  (bus.pe_req_valid),
        .pe_req_ready_i  (bus.pe_req_ready),
        .busy_o          (bus.busy),
        .stall_cycles_o  (bus.stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        pe_req_t        req;
        logic [Pes-1:0] mask;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_stall = '0;

    function automatic pe_req_t model_prune(pe_req_t r, logic [7:0] run);
        pe_req_t p = r;
        p.hazard_vs1    = r.hazard_vs1 & run;
        p.hazard_vs2    = r.hazard_vs2 & run;
        p.hazard_vd     = r.hazard_vd & run;
        p.hazard_vm     = r.hazard_vm & run;
        p.vinsn_running = run;
        return p;
    endfunction

    function automatic pe_req_t mk_req(input logic [2:0] id, input logic [7:0] hz);
        pe_req_t r = '0;
        r.id = id;  r.op = 8'h10 + 8'(id);  r.vfu = VFU_Alu;
        r.vs1 = 5'd1;  r.vs2 = 5'd2;  r.vd = 5'(id) + 5'd3;  r.vm = 1'b1;
        r.vl = 16'd100 + 16'(id);
        r.hazard_vs1 = hz;  r.hazard_vs2 = hz;  r.hazard_vd = hz;  r.hazard_vm = hz;
        r.vinsn_running = 8'hAA;
        return r;
    endfunction

    // Scoreboard: checks the observable state, then advances the model across the next edge
    always @(negedge clk) begin : mon
        exp_t           e;
        int             sz;
        logic [Pes-1:0] ev;
        bit             pop;
        #3;
        if (rst) begin
            n_checks++;
            if (bus.pe_req_valid !== '0 || bus.pe_req !== '0 || bus.busy !== 1'b0 ||
                bus.stall_cycles !== 16'd0 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_reset valid=%b busy=%b stall=%0d ready=%b required all zero",
                         bus.pe_req_valid, bus.busy, bus.stall_cycles, bus.req_ready);
            end
            sb.delete();
            m_stall = '0;
        end else begin
            sz  = sb.size();
            ev  = (sz != 0) ? sb[0].mask : '0;
            pop = 1'b0;
            n_checks++;
            if (bus.pe_req_valid !== ev) begin
                n_fail++;
                $display("FAIL sb_valid got=%b required=%b", bus.pe_req_valid, ev);
            end
            n_checks++;
            if (bus.busy !== (sz != 0) || bus.req_ready !== (sz < Dep)) begin
                n_fail++;
                $display("FAIL sb_busy_ready busy=%b ready=%b required busy=%b ready=%b",
                         bus.busy, bus.req_ready, sz != 0, sz < Dep);
            end
            n_checks++;
            if (bus.stall_cycles !== m_stall) begin
                n_fail++;
                $display("FAIL sb_stall got=%0d required=%0d", bus.stall_cycles, m_stall);
            end
            n_checks++;
            if (sz != 0 && bus.pe_req !== sb[0].req) begin
                n_fail++;
                $display("FAIL sb_head got id=%0d vl=%0d hvd=%h run=%h required id=%0d vl=%0d hvd=%h run=%h",
                         bus.pe_req.id, bus.pe_req.vl, bus.pe_req.hazard_vd, bus.pe_req.vinsn_running,
                         sb[0].req.id, sb[0].req.vl, sb[0].req.hazard_vd, sb[0].req.vinsn_running);
            end else if (sz == 0 && bus.pe_req !== '0) begin
                n_fail++;
                $display("FAIL sb_head_empty got=%h required=0", bus.pe_req);
            end
            if (sz != 0) begin
                e      = sb[0];
                e.mask = e.mask & ~bus.pe_req_ready;
                sb[0]  = e;
                pop    = (e.mask == '0);
            end
            if (pop) begin
                void'(sb.pop_front());
                m_stall = '0;
            end else if (sz != 0 && m_stall != 16'hFFFF) begin
                m_stall = m_stall + 16'd1;
            end
            if (bus.req_valid && sz < Dep && bus.req_pes != '0) begin
                e.req  = bus.req;
                e.mask = bus.req_pes;
                sb.push_back(e);
            end
            for (int i = 0; i < sb.size(); i++) begin
                e       = sb[i];
                e.req   = model_prune(e.req, bus.vinsn_running);
                sb[i]   = e;
            end
        end
    end

    task automatic idle_in();
        bus.req_valid = 1'b0;
        bus.req_pes   = '0;
        bus.req       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        bus.pe_req_ready  = '0;
        bus.vinsn_running = 8'hFF;
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b required=0", bus.req_ready); end
        n_checks++;
        if (bus.pe_req_valid !== '0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_busy valid=%b busy=%b required 0", bus.pe_req_valid, bus.busy);
        end
        n_checks++;
        if (bus.stall_cycles !== 16'd0 || bus.pe_req !== '0) begin
            n_fail++; $display("FAIL reset_stall_req stall=%0d req=%h required 0", bus.stall_cycles, bus.pe_req);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b required=1", bus.req_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req = mk_req(3'd1, 8'hFF);  bus.req_pes = 5'b11111;  bus.req_valid = 1'b1;
        bus.pe_req_ready = '1;
        #2;
        n_checks++;
        if (bus.pe_req_valid !== 5'b00000) begin n_fail++; $display("FAIL single_t0_valid got=%b required=00000", bus.pe_req_valid); end
        @(negedge clk);
        idle_in();
        #2;
        n_checks++;
        if (bus.pe_req_valid !== 5'b11111 || bus.busy !== 1'b1 || bus.pe_req.id !== 3'd1) begin
            n_fail++;
            $display("FAIL single_t1 valid=%b busy=%b id=%0d required 11111 1 1", bus.pe_req_valid, bus.busy, bus.pe_req.id);
        end
        @(negedge clk);
        #2;
        n_checks++;
        if (bus.pe_req_valid !== 5'b00000 || bus.busy !== 1'b0 || bus.stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL single_t2 valid=%b busy=%b stall=%0d required 00000 0 0", bus.pe_req_valid, bus.busy, bus.stall_cycles);
        end
    endtask

    task automatic test_staggered();
        logic [Pes-1:0] rdy [5]   = '{5'b00001, 5'b00000, 5'b00000, 5'b10000, 5'b00000};
        logic [Pes-1:0] vexp [5]  = '{5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b00000};
        logic [15:0]    sexp [5]  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        bus.pe_req_ready = '0;
        @(negedge clk);
        bus.req = mk_req(3'd2, 8'h01);  bus.req_pes = 5'b10001;  bus.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle_in();
            bus.pe_req_ready = rdy[c];
            #2;
            n_checks++;
            if (bus.pe_req_valid !== vexp[c] || bus.stall_cycles !== sexp[c]) begin
                n_fail++;
                $display("FAIL stagger_c%0d valid=%b stall=%0d required valid=%b stall=%0d",
                         c, bus.pe_req_valid, bus.stall_cycles, vexp[c], sexp[c]);
            end
        end
    endtask

    task automatic test_fill();
        logic       rexp  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] idexp [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd3};
        bus.pe_req_ready = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req       = mk_req(3'(2 + (c > 2 ? 2 : c)), 8'hFF);
            bus.req_pes   = 5'b11111;
            bus.req_valid = 1'b1;
            if (c >= 3) bus.pe_req_ready = '1;
            #2;
            n_checks++;
            if (bus.req_ready !== rexp[c] || (c >= 2 && bus.pe_req.id !== idexp[c])) begin
                n_fail++;
                $display("FAIL fill_c%0d ready=%b head=%0d required ready=%b head=%0d",
                         c, bus.req_ready, bus.pe_req.id, rexp[c], idexp[c]);
            end
        end
        @(negedge clk);
        idle_in();
        #2;
        n_checks++;
        if (bus.pe_req.id !== 3'd4 || bus.pe_req_valid !== 5'b11111) begin
            n_fail++; $display("FAIL fill_last head=%0d valid=%b required 4 11111", bus.pe_req.id, bus.pe_req_valid);
        end
        @(negedge clk);
        #2;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fill_drain busy=%b required=0", bus.busy); end
    endtask

    task automatic test_hazard();
        pe_req_t r = mk_req(3'd5, 8'h00);
        r.hazard_vd = 8'h06;
        bus.pe_req_ready  = '0;
        bus.vinsn_running = 8'hFF;
        @(negedge clk);
        bus.req = r;  bus.req_pes = 5'b00001;  bus.req_valid = 1'b1;
        @(negedge clk);
        idle_in();
        bus.vinsn_running = 8'hFD;
        #2;
        n_checks++;
        if (bus.pe_req.hazard_vd !== 8'h06) begin n_fail++; $display("FAIL hazard_before got=%h required=06", bus.pe_req.hazard_vd); end
        @(negedge clk);
        bus.pe_req_ready = 5'b00001;
        #2;
        n_checks++;
        if (bus.pe_req.hazard_vd !== 8'h04 || bus.pe_req.vinsn_running !== 8'hFD) begin
            n_fail++; $display("FAIL hazard_after hvd=%h run=%h required 04 fd", bus.pe_req.hazard_vd, bus.pe_req.vinsn_running);
        end
        n_checks++;
        if (bus.pe_req.id !== 3'd5 || bus.pe_req.vl !== 16'd105 || bus.pe_req.vd !== 5'd8 || bus.pe_req.hazard_vs1 !== 8'h00) begin
            n_fail++;
            $display("FAIL hazard_other id=%0d vl=%0d vd=%0d hvs1=%h required 5 105 8 00",
                     bus.pe_req.id, bus.pe_req.vl, bus.pe_req.vd, bus.pe_req.hazard_vs1);
        end
        @(negedge clk);
        bus.pe_req_ready  = '0;
        bus.vinsn_running = 8'hFF;
    endtask

    task automatic test_zero_mask();
        @(negedge clk);
        bus.req = mk_req(3'd6, 8'hFF);  bus.req_pes = '0;  bus.req_valid = 1'b1;
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got=%b required=1", bus.req_ready); end
        repeat (2) begin
            @(negedge clk);
            idle_in();
            #2;
            n_checks++;
            if (bus.busy !== 1'b0 || bus.pe_req_valid !== '0) begin
                n_fail++; $display("FAIL zero_dropped busy=%b valid=%b required 0 00000", bus.busy, bus.pe_req_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.pe_req_ready = '0;
        @(negedge clk);
        bus.req = mk_req(3'd1, 8'hFF);  bus.req_pes = 5'b00011;  bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req = mk_req(3'd2, 8'hFF);  bus.req_pes = 5'b01100;
        @(negedge clk);
        idle_in();
        #2;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.pe_req_valid !== 5'b00011 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_before busy=%b valid=%b ready=%b required 1 00011 0", bus.busy, bus.pe_req_valid, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.pe_req_valid !== '0 || bus.pe_req !== '0 ||
            bus.stall_cycles !== 16'd0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_during busy=%b valid=%b stall=%0d ready=%b required all zero",
                     bus.busy, bus.pe_req_valid, bus.stall_cycles, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req = mk_req(3'd7, 8'hFF);  bus.req_pes = 5'b11111;  bus.req_valid = 1'b1;
        bus.pe_req_ready = '1;
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b required=1", bus.req_ready); end
        @(negedge clk);
        idle_in();
        #2;
        n_checks++;
        if (bus.pe_req_valid !== 5'b11111 || bus.pe_req.id !== 3'd7) begin
            n_fail++; $display("FAIL rstmid_after valid=%b id=%0d required 11111 7", bus.pe_req_valid, bus.pe_req.id);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [Pes-1:0] m0 = pe_mask(VFU_Alu, 1'b0);
        logic [Pes-1:0] m1 = pe_mask(VFU_LoadUnit, 1'b1);
        logic [Pes-1:0] prev = '0;
        n_checks++;
        if (m0 !== 5'b01001 || m1 !== 5'b00101) begin
            n_fail++; $display("FAIL pe_mask alu_masked=%b load=%b required 01001 00101", m0, m1);
        end
        bus.pe_req_ready = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                bus.req       = mk_req(3'(k), 8'h0F);
                bus.req_pes   = k[0] ? m1 : m0;
                bus.req_valid = 1'b1;
            end else begin
                idle_in();
            end
            #2;
            n_checks++;
            if (bus.req_ready !== 1'b1 || (k > 0 && (bus.pe_req.id !== 3'(k - 1) || bus.pe_req_valid !== prev))) begin
                n_fail++;
                $display("FAIL b2b_k%0d ready=%b id=%0d valid=%b required 1 %0d %b",
                         k, bus.req_ready, bus.pe_req.id, bus.pe_req_valid, k - 1, prev);
            end
            prev = k[0] ? m1 : m0;
        end
        @(negedge clk);
        #2;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain busy=%b required=0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_staggered();
        test_fill();
        test_hazard();
        test_zero_mask();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover entries=%0d required=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ara_pe_req_broadcast.md
# ara_pe_req_broadcast

Decouples Ara's sequencer from the processing elements (PEs). Each vector-instruction request is queued and broadcast to a per-request subset of PEs. Every PE accepts on its own cycle, so the sequencer no longer waits for all PEs to be ready at the same time. Queued requests have their hazard bits pruned every cycle as instructions complete. The block sits between the sequencer's `pe_req` output and the lanes, load/store, slide and mask units.

## Interface
- `NrPEs`, default 5: number of PE destinations (lanes + 4 units).
- `NrVInsn`, default 8: number of vector instruction IDs; equals `ara_pkg::NrVInsn`.
- `Depth`, default 2: queue entries, ≥2, power of two.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  `pe_req_t`  request from the sequencer.
- `req_pes_i`  in  NrPEs  target PE mask for `req_i`.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i` and `req_ready_o` are both high.
- `vinsn_running_i`  in  NrVInsn  instructions currently running.
- `pe_req_o`  out  `pe_req_t`  head request, shared by all PEs.
- `pe_req_valid_o`  out  NrPEs  per-PE valid.
- `pe_req_ready_i`  in  NrPEs  per-PE ready.
- `busy_o`  out  1  queue non-empty.
- `stall_cycles_o`  out  16  cycles the current head has waited, saturating.

## Operation
- Queue: circular buffer of `Depth` entries. Each entry holds a `pe_req_t` and a `pending` mask of NrPEs bits. Read and write pointers are log2(Depth) bits and wrap naturally. An occupancy counter is log2(Depth)+1 bits.
- `req_ready_o = !full && !rst_i`. There is no full-queue bypass: a pop and an accept in the same cycle while full is not possible.
- Enqueue on handshake:
  - the entry gets `req_i`;
  - its `pending` gets `req_pes_i`;
  - its `hazard_vs1`, `hazard_vs2`, `hazard_vd` and `hazard_vm` are ANDed with `vinsn_running_i`;
  - its `vinsn_running` is set to `vinsn_running_i`.
- Zero mask: a handshake with `req_pes_i == 0` is accepted and dropped. It does not enqueue and has no other effect.
- Broadcast:
  - `pe_req_o` is the head entry, or `'0` when the queue is empty;
  - `pe_req_valid_o = head.pending`, gated by non-empty.
- PE acceptance: PE p accepts when `pe_req_valid_o[p] && pe_req_ready_i[p]`. The head clears `pending[p]`.
- Pop: the head pops in the cycle its last pending bit is accepted, whether one PE or several accept that cycle. The next entry presents its request on the following cycle.
- Hazard refresh, applied to every occupied entry every cycle:
  - the four hazard fields are ANDed with `vinsn_running_i`;
  - `vinsn_running` is set to `vinsn_running_i`.
- Stall counter: `stall_cycles_o` increments on each cycle the queue is non-empty and no pop occurs. It clears to 0 on pop and saturates at 0xFFFF.
- Simultaneous events in one cycle (enqueue, PE acceptances, pop, refresh) all take effect together. An enqueue into an empty queue is never popped in its enqueue cycle.

## Timing
- Latency: a request accepted in cycle t appears on `pe_req_o` / `pe_req_valid_o` in cycle t+1 if the queue was empty. Otherwise it appears in the cycle after the previous head pops.
- Back-to-back: 1 request/cycle sustained when every targeted PE is ready.
- Hazard bits lag `vinsn_running_i` by one cycle. This is conservative and safe.
- `pe_req_valid_o[p]` must not drop until PE p accepts.
- Once PE p has accepted, `pe_req_valid_o[p]` stays low for that request.
- `pe_req_o` contents may change only in their hazard fields and `vinsn_running` while a request is held.
- Values while `rst_i` is asserted, held until the first clock after deassertion:
  - queue empty, pointers and pending masks 0;
  - `pe_req_o = '0`, `pe_req_valid_o = 0`;
  - `busy_o = 0`, `stall_cycles_o = 0`, `req_ready_o = 0`.
- Reset mid-operation discards all queued requests immediately; no partial broadcast completes.

## Structure
- `pe_req_t`, `vid_t`, `NrVInsn`, and the PE offsets (`OffsetLoad`, `OffsetStore`, `OffsetSlide`, `OffsetMask`) come from `ara_pkg`. Add no new package types.
- The PE-mask helper function lives in `ara_pkg`: it builds `req_pes_i` from a `vfu_e` plus the `vm` bit, so that masked instructions also target the mask unit.
- Single module. The storage needs per-entry refresh, so it is hand-written rather than built on a generic FIFO. No sub-module.

## Test plan
- Single request, `req_pes_i = 5'b11111`, all PEs ready -> valid `11111` in cycle t+1 only; `busy_o` goes 1 → 0; `stall_cycles_o = 0`.
- Staggered readiness: `req_pes_i = 5'b10001`; PE0 ready in cycle 2, PE4 ready in cycle 5 -> valid `10001`, then `10000`; pop in cycle 5; `stall_cycles_o` reaches 3 before the pop.
- Fill: 3 requests presented with all PEs stalled -> `req_ready_o = 0` after 2 accepts; the third is accepted the cycle after the first pop; order is preserved.
- Hazard refresh: queued `hazard_vd = 8'h06`, `vinsn_running_i` drops bit 1 -> `pe_req_o.hazard_vd = 8'h04` one cycle later; the other fields are unchanged.
- Zero mask: `req_pes_i = 0` with valid -> accepted; `busy_o` stays 0; `pe_req_valid_o` stays 0.
- Reset mid-broadcast: assert `rst_i` with 2 entries queued -> all outputs at their reset values the same cycle; after deassertion a new request is broadcast normally at t+1.
